// File: rtl/rsa_pkg.sv
// Shared state encoding and default operand width for the RSA
// modular exponentiation core and its modular multiplier.
package rsa_pkg;

    localparam int RSA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        UPDATE,
        DONE
    } state_t;

endpackage

// File: rtl/rsa_modexp_core_if.sv
// Request/result bundle of the modular exponentiation core.
// The requester owns the operands and start; the core owns status and result.
interface rsa_modexp_core_if
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] msg;
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] modulus;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;

    modport master (
        output start, msg, exp, modulus,
        input  busy, done, result, err
    );

    modport slave (
        input  start, msg, exp, modulus,
        output busy, done, result, err
    );

endinterface

// File: rtl/rsa_modmul.sv
// Bit-serial interleaved modular multiplier: product = a*b mod n after WIDTH
// steps, consuming the multiplier b MSB first. Requires a < n.
module rsa_modmul
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   red1;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   red2;

    // One extra bit keeps 2P and P+a (both below 2n) from overflowing.
    always_comb begin
        dbl  = {p, 1'b0};
        red1 = (dbl >= {1'b0, n_r}) ? dbl - {1'b0, n_r} : dbl;
        sum  = b_r[WIDTH-1] ? red1 + {1'b0, a_r} : red1;
        red2 = (sum >= {1'b0, n_r}) ? sum - {1'b0, n_r} : sum;
    end

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p   <= '0;
            a_r <= '0;
            b_r <= '0;
            n_r <= '0;
        end else if (load) begin
            p   <= '0;
            a_r <= a;
            b_r <= b;
            n_r <= n;
        end else if (step) begin
            p   <= red2[WIDTH-1:0];
            b_r <= b_r << 1;
        end
    end

    assign product = p;

endmodule

// File: rtl/rsa_modexp_core.sv
// Constant-time right-to-left square-and-multiply M^e mod n, built from two
// bit-serial modular multipliers running in lock step (acc*base, base*base).
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH
) (
    input logic               clk,
    input logic               reset_n,
    rsa_modexp_core_if.slave  bus
);

    localparam int               IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] exp_r;
    logic [WIDTH-1:0] mod_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] base;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] cnt;
    logic [WIDTH-1:0] result_r;
    logic             err_r;

    logic             operands_ok;
    logic [WIDTH-1:0] acc_prod;
    logic [WIDTH-1:0] sq_prod;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] base_next;
    logic             mul_load;
    logic             mul_step;
    logic [WIDTH-1:0] ld_acc;
    logic [WIDTH-1:0] ld_base;
    logic [WIDTH-1:0] ld_n;

    assign operands_ok = (bus.modulus >= WIDTH'(2)) && (bus.msg < bus.modulus);
    assign acc_next    = exp_r[bit_idx] ? acc_prod : acc;
    assign base_next   = sq_prod;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        mul_load   = 1'b0;
        mul_step   = 1'b0;
        ld_acc     = acc_next;
        ld_base    = base_next;
        ld_n       = mod_r;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (operands_ok) begin
                        state_next = MUL;
                        mul_load   = 1'b1;
                        ld_acc     = WIDTH'(1);
                        ld_base    = bus.msg;
                        ld_n       = bus.modulus;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            MUL: begin
                mul_step = 1'b1;
                if (cnt == LAST) state_next = UPDATE;
            end
            UPDATE: begin
                if (bit_idx == LAST) begin
                    state_next = DONE;
                end else begin
                    state_next = MUL;
                    mul_load   = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            exp_r    <= '0;
            mod_r    <= '0;
            acc      <= '0;
            base     <= '0;
            bit_idx  <= '0;
            cnt      <= '0;
            result_r <= '0;
            err_r    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        exp_r    <= bus.exp;
                        mod_r    <= bus.modulus;
                        acc      <= WIDTH'(1);
                        base     <= bus.msg;
                        bit_idx  <= '0;
                        cnt      <= '0;
                        result_r <= '0;
                        err_r    <= !operands_ok;
                    end
                end
                MUL: cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                UPDATE: begin
                    acc     <= acc_next;
                    base    <= base_next;
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == LAST) result_r <= acc_next;
                end
                default: ;
            endcase
        end
    end

    rsa_modmul #(.WIDTH(WIDTH)) u_mul_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (mul_load),
        .step    (mul_step),
        .a       (ld_acc),
        .b       (ld_base),
        .n       (ld_n),
        .product (acc_prod)
    );

    rsa_modmul #(.WIDTH(WIDTH)) u_mul_sq (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (mul_load),
        .step    (mul_step),
        .a       (ld_base),
        .b       (ld_base),
        .n       (ld_n),
        .product (sq_prod)
    );

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_r;
    assign bus.err    = err_r;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Directed and random checks of rsa_modexp_core against a plain-arithmetic
// square-and-multiply model; outputs are sampled on the falling clock edge.
module tb_rsa_modexp_core;
    import rsa_pkg::*;

    localparam int W     = RSA_WIDTH;
    localparam int LAT   = W * (W + 1) + 1;
    localparam int LIMIT = 3000;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;

    rsa_modexp_core_if #(.WIDTH(W)) bus ();

    rsa_modexp_core #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] m, e, n);
        logic [63:0] r;
        logic [63:0] b;
        if (n < 2 || m >= n) return '0;
        r = 64'd1;
        b = 64'(m);
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * b) % 64'(n);
            b = (b * b) % 64'(n);
        end
        return r[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    // Waits (bounded) for done; optionally scrambles inputs and re-pulses start.
    task automatic wait_done(input int cyc0, input int pulse_at, input logic scramble,
                             output int cyc);
        cyc = cyc0;
        while (bus.done !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (scramble && cyc == 10) begin
                bus.msg     = $urandom;
                bus.exp     = $urandom;
                bus.modulus = $urandom;
            end
            if (cyc == pulse_at)     bus.start = 1'b1;
            if (cyc == pulse_at + 1) bus.start = 1'b0;
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] m, e, n,
                         input logic [W-1:0] want, input int pulse_at);
        int   cyc;
        logic inv;
        inv = (n < 2) || (m >= n);
        @(negedge clk);
        bus.msg     = m;
        bus.exp     = e;
        bus.modulus = n;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, ".busy"}, 64'(bus.busy), 64'd1);
        wait_done(1, pulse_at, 1'b1, cyc);
        check({tag, ".done"}, 64'(bus.done), 64'd1);
        check({tag, ".latency"}, 64'(cyc), inv ? 64'd1 : 64'(LAT));
        check({tag, ".result"}, 64'(bus.result), 64'(want));
        check({tag, ".err"}, 64'(bus.err), 64'(inv));
        @(negedge clk);
        check({tag, ".single_done"}, 64'(bus.done), 64'd0);
        check({tag, ".idle"}, 64'(bus.busy), 64'd0);
        check({tag, ".hold_result"}, 64'(bus.result), 64'(want));
        check({tag, ".hold_err"}, 64'(bus.err), 64'(inv));
    endtask

    initial begin
        logic [W-1:0] m;
        logic [W-1:0] e;
        logic [W-1:0] n;
        int           cyc;
        int           seen;

        bus.start   = 1'b0;
        bus.msg     = '0;
        bus.exp     = '0;
        bus.modulus = '0;

        repeat (2) @(negedge clk);
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.result", 64'(bus.result), 64'd0);
        check("reset.err", 64'(bus.err), 64'd0);
        reset_n = 1'b1;

        do_op("vec_4_13_497", 32'd4, 32'd13, 32'd497, 32'd445, 0);
        do_op("rsa_enc", 32'd65, 32'd17, 32'd3233, 32'd2790, 0);
        do_op("rsa_dec", 32'd2790, 32'd2753, 32'd3233, 32'd65, 0);
        do_op("exp_zero", 32'd5, 32'd0, 32'd7, 32'd1, 0);
        do_op("msg_zero", 32'd0, 32'd9, 32'd7, 32'd0, 0);
        do_op("mod_one", 32'd0, 32'd3, 32'd1, 32'd0, 0);
        do_op("msg_ge_mod", 32'd500, 32'd3, 32'd497, 32'd0, 0);
        do_op("restart_ignored", 32'd4, 32'd13, 32'd497, 32'd445, 100);

        // Random valid operands: large modulus, then small modulus.
        for (int i = 0; i < 4; i++) begin
            n = $urandom;
            if (i[0]) n = $urandom_range(2, 100000);
            if (n < 2) n = 32'd3;
            m = $urandom % n;
            e = $urandom;
            do_op($sformatf("rand%0d", i), m, e, n, ref_modexp(m, e, n), 0);
        end
        n = $urandom_range(2, 100000);
        m = n + $urandom_range(0, 50);
        do_op("rand_invalid", m, $urandom, n, ref_modexp(m, 32'd1, n), 0);

        // start held high across DONE launches the next operation back to back.
        @(negedge clk);
        bus.msg = 32'd4; bus.exp = 32'd13; bus.modulus = 32'd497; bus.start = 1'b1;
        @(negedge clk);
        wait_done(1, 0, 1'b0, cyc);
        check("held.a.latency", 64'(cyc), 64'(LAT));
        check("held.a.result", 64'(bus.result), 64'd445);
        bus.msg = 32'd65; bus.exp = 32'd17; bus.modulus = 32'd3233;
        @(negedge clk);
        check("held.gap_idle", 64'(bus.busy), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        check("held.b.accepted", 64'(bus.busy), 64'd1);
        wait_done(1, 0, 1'b0, cyc);
        check("held.b.latency", 64'(cyc), 64'(LAT));
        check("held.b.result", 64'(bus.result), 64'd2790);
        @(negedge clk);

        // Reset in the middle of an operation aborts it without a done pulse.
        @(negedge clk);
        bus.msg = 32'd65; bus.exp = 32'd17; bus.modulus = 32'd3233; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (499) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort.busy", 64'(bus.busy), 64'd0);
        check("abort.done", 64'(bus.done), 64'd0);
        check("abort.result", 64'(bus.result), 64'd0);
        check("abort.err", 64'(bus.err), 64'd0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        check("abort.no_done", 64'(seen), 64'd0);
        reset_n     = 1'b1;
        bus.msg     = 32'd2790;
        bus.exp     = 32'd2753;
        bus.modulus = 32'd3233;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("post_reset.first_accept", 64'(bus.busy), 64'd1);
        wait_done(1, 0, 1'b0, cyc);
        check("post_reset.latency", 64'(cyc), 64'(LAT));
        check("post_reset.result", 64'(bus.result), 64'd65);
        check("post_reset.err", 64'(bus.err), 64'd0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
